// File: rtl/wr_back_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wr_back_buf : packs a DVP fval/lval/pixel stream into readback-FIFO words
// Rev 1.0
// ---------------------------------------------------------------------------
module wr_back_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WORDS  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_fval,
  input  logic                  i_lval,
  input  logic [DATA_WIDTH-1:0] iv_pix_data,
  input  logic                  i_full,
  output logic                  o_wr,
  output logic [DATA_WIDTH:0]   ov_wr_data,
  output logic                  o_overflow,
  output logic [15:0]           ov_frame_cnt,
  output logic [15:0]           ov_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_DROP   = 3'd2,
    S_GAP    = 3'd3,
    S_SKIP   = 3'd4
  } state_t;

  localparam logic [3:0] c_gap_last = 4'(GAP_WORDS - 1);

  state_t              state_q, state_d;
  logic                fval_dly_q, fval_dly_d;
  logic                armed_q, armed_d;
  logic                wr_req_q, wr_req_d;
  logic [DATA_WIDTH:0] wr_data_q, wr_data_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                skip_q, skip_d;
  logic                trunc_q, trunc_d;
  logic                pix_wr_q, pix_wr_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;

  logic w_rise, w_fall, w_pix, w_accept, w_lost, w_skip_next;

  // armed_q blocks a frame already in progress when reset is released
  assign w_rise   = i_fval & ~fval_dly_q & armed_q;
  assign w_fall   = ~i_fval & fval_dly_q;
  assign w_pix    = i_fval & i_lval;
  assign w_accept = wr_req_q & ~i_full;
  assign w_lost   = (state_q == S_ACTIVE) & wr_req_q & i_full;

  assign o_wr         = wr_req_q & ~i_full;
  assign ov_wr_data   = wr_data_q;
  assign o_overflow   = w_lost;
  assign ov_frame_cnt = frame_cnt_q;
  assign ov_drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    fval_dly_d  = i_fval;
    armed_d     = armed_q | ~i_fval;
    wr_req_d    = 1'b0;
    wr_data_d   = wr_data_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    skip_d      = skip_q;
    trunc_d     = trunc_q;
    pix_wr_d    = pix_wr_q;
    gap_cnt_d   = gap_cnt_q;
    w_skip_next = skip_q | w_rise;

    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          state_d  = S_ACTIVE;
          trunc_d  = 1'b0;
          pix_wr_d = 1'b0;
          if (i_lval) begin
            wr_req_d  = 1'b1;
            wr_data_d = {1'b1, iv_pix_data};
          end
        end
      end

      S_ACTIVE: begin
        if (w_accept) pix_wr_d = 1'b1;
        if (w_lost) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          trunc_d    = 1'b1;
          if (w_fall) begin
            if (pix_wr_q) begin
              state_d   = S_GAP;
              wr_req_d  = 1'b1;
              wr_data_d = '0;
              gap_cnt_d = 4'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_DROP;
          end
        end else if (w_fall) begin
          state_d   = S_GAP;
          wr_req_d  = 1'b1;
          wr_data_d = '0;
          gap_cnt_d = 4'd0;
        end else if (w_pix) begin
          wr_req_d  = 1'b1;
          wr_data_d = {1'b1, iv_pix_data};
        end
      end

      S_DROP: begin
        if (!i_fval) begin
          if (pix_wr_q) begin
            state_d   = S_GAP;
            wr_req_d  = 1'b1;
            wr_data_d = '0;
            gap_cnt_d = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        // A frame starting during the gap is counted once and skipped whole
        if (w_rise && !skip_q) begin
          skip_d     = 1'b1;
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (w_accept) begin
          if (gap_cnt_q == c_gap_last) begin
            if (!trunc_q) frame_cnt_d = frame_cnt_q + 16'd1;
            skip_d  = 1'b0;
            state_d = w_skip_next ? S_SKIP : S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
            wr_req_d  = 1'b1;
          end
        end else begin
          wr_req_d = 1'b1;
        end
      end

      S_SKIP: begin
        if (!i_fval) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      fval_dly_q  <= 1'b0;
      armed_q     <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      skip_q      <= 1'b0;
      trunc_q     <= 1'b0;
      pix_wr_q    <= 1'b0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      fval_dly_q  <= fval_dly_d;
      armed_q     <= armed_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      skip_q      <= skip_d;
      trunc_q     <= trunc_d;
      pix_wr_q    <= pix_wr_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/wr_back_buf.md
# wr_back_buf

Front-end writer for the frame-buffer readback FIFO. Samples a DVP-style video stream (`fval`/`lval`/pixel) and packs it into FIFO words: pixel words carry `{1, pixel}` and frame-separator words carry `{0, 0}`. A downstream FIFO reader regenerates `fval`/`lval` from bit `DATA_WIDTH` of each word. On FIFO overflow the writer truncates or drops the frame cleanly, so the reader never sees a torn frame boundary.

## Interface
- `DATA_WIDTH`, default 8: pixel width. The FIFO word is `DATA_WIDTH+1` bits.
- `GAP_WORDS`, default 2, range 1..15: number of separator words written after each frame.
- `clk`  in  1: single clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `i_fval`  in  1: frame valid.
- `i_lval`  in  1: line valid. Ignored while `i_fval` = 0.
- `iv_pix_data`  in  DATA_WIDTH: pixel, valid when `i_fval & i_lval`.
- `i_full`  in  1: FIFO full, from the FIFO write side.
- `o_wr`  out  1: FIFO write enable.
- `ov_wr_data`  out  DATA_WIDTH+1: FIFO write word.
- `o_overflow`  out  1: one-cycle pulse when a pixel is lost to `i_full`.
- `ov_frame_cnt`  out  16: frames written complete. Wraps.
- `ov_drop_cnt`  out  16: frames truncated or skipped. Wraps.

## Operation
- Input register stage: `fval_d` holds previous `i_fval`. `rise = i_fval & ~fval_d`. `fall = ~i_fval & fval_d`.
- Internal write request `wr_req` and `ov_wr_data` are registered. `o_wr = wr_req & ~i_full` (combinational), so no write ever occurs while full.
- States:
  - IDLE: wait for `rise` → ACTIVE. A pixel on the rise cycle (`i_lval` = 1) is written. `i_fval` already high at reset release does not start a frame; the writer waits for the next rise.
  - ACTIVE: each cycle with `i_fval & i_lval` issues `wr_req` with word `{1'b1, iv_pix_data}`.
    - `fall` → GAP.
    - A pixel request that meets `i_full` = 1 at its `o_wr` cycle is lost: pulse `o_overflow`, increment `ov_drop_cnt`, go to DROP.
  - DROP: no pixel writes. On `i_fval` = 0 → GAP if at least one pixel of this frame was written, else → IDLE.
  - GAP: issue `GAP_WORDS` separator words `{1'b0, {DATA_WIDTH{1'b0}}}`. Each word holds `wr_req` until it is accepted (`o_wr` = 1); `i_full` stalls, never drops.
    - After the last accepted word: increment `ov_frame_cnt` only if the frame was not truncated, then go to IDLE.
    - A `rise` seen while in GAP sets a skip flag and increments `ov_drop_cnt`. On GAP exit with skip set → SKIP instead of IDLE.
  - SKIP: no writes. `i_fval` = 0 → IDLE.
- Counters wrap modulo 2^16. Each counter increments at most once per frame.

## Timing
- Latency: input sample at edge N → `wr_req` and `ov_wr_data` valid after edge N+1. `o_wr` follows `i_full` in the same cycle.
- Pixel throughput is 1 word per clock. Back-to-back lines need no idle cycles.
- The first separator is requested on the cycle after `fall` is detected. Minimum GAP duration is `GAP_WORDS` cycles.
- `o_overflow` is high for exactly the cycle of the lost write.
- Reset values: `o_wr` = 0, `ov_wr_data` = 0, `o_overflow` = 0, both counters = 0, state IDLE, `fval_d` = 0, skip flag = 0.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous). The partial frame is not terminated and not counted.

## Test plan
- Nominal frame: DATA_WIDTH = 8, GAP_WORDS = 2, 2 lines × 4 pixels 0x10..0x17, `i_full` = 0 → 8 words 0x110..0x117, then 0x000, 0x000; `ov_frame_cnt` = 1; `ov_drop_cnt` = 0.
- Mid-frame overflow: assert `i_full` on the 3rd pixel of line 1 → 2 pixel words written, `o_overflow` pulses once, no further pixels; after `fall`, 2 separators are written once `i_full` clears; `ov_drop_cnt` = 1, `ov_frame_cnt` = 0.
- Full from frame start: `i_full` = 1 at rise → 0 words written, `ov_drop_cnt` = 1, return to IDLE, nothing written.
- Separator stall: `i_full` = 1 for 5 cycles right after `fall` → `o_wr` = 0 for those cycles; both separators are written afterwards; none are lost.
- Rise during GAP: GAP_WORDS = 4, `i_full` held high, next frame rises → that frame writes no words, `ov_drop_cnt` += 1; the following frame is written normally.
- Reset release with `i_fval` high → no writes until `i_fval` falls and rises again; then the frame is written normally.
